v_regfile: RTL and testbench

V_REGFILE -- requirements
Module: v_regfile

---
 rtl/v_regfile.sv | 99 +++++++++
 tb/tb_v_regfile.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/v_regfile.sv
// Vector register file with combinational read ports, same-cycle write
// bypass, and a per-register pending scoreboard. The scoreboard tracks
// issued-but-not-written-back destinations and flags protocol misuse.
module v_regfile #(
  parameter int VREG_NUM = 32,
  parameter int VREG_AW  = 5,
  parameter int VLEN     = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vwb_en_i,
  input  logic [VREG_AW-1:0] vwb_addr_i,
  input  logic [VLEN-1:0]    vwb_data_i,
  input  logic               vid_issue_en_i,
  input  logic [VREG_AW-1:0] vid_issue_addr_i,
  input  logic [VREG_AW-1:0] vrs1_addr_i,
  input  logic [VREG_AW-1:0] vrs2_addr_i,
  output logic [VLEN-1:0]    vrs1_data_o,
  output logic [VLEN-1:0]    vrs2_data_o,
  output logic               vrs1_busy_o,
  output logic               vrs2_busy_o,
  output logic               vscb_err_o
);

  logic [VLEN-1:0]     regs [VREG_NUM];
  logic [VREG_NUM-1:0] pending;
  logic                err_q;

  logic wb_ok;
  logic iss_ok;
  logic same_addr;
  logic err_iss;
  logic err_wb;
  logic rs1_ok;
  logic rs2_ok;
  logic rs1_byp;
  logic rs2_byp;

  // Addresses at or above VREG_NUM have no backing register and are ignored.
  function automatic logic in_range(input logic [VREG_AW-1:0] a);
    return 32'(a) < 32'(VREG_NUM);
  endfunction

  // Qualify write-back/issue and detect scoreboard protocol violations.
  // A same-address issue and write-back in one cycle is a legal hand-over
  // to a new producer, so neither side counts as an error then.
  always_comb begin
    wb_ok     = vwb_en_i && in_range(vwb_addr_i);
    iss_ok    = vid_issue_en_i && in_range(vid_issue_addr_i);
    same_addr = (vwb_addr_i == vid_issue_addr_i);
    err_iss   = 1'b0;
    err_wb    = 1'b0;
    if (iss_ok)
      err_iss = pending[vid_issue_addr_i] && !(wb_ok && same_addr);
    if (wb_ok)
      err_wb = !pending[vwb_addr_i] && !(iss_ok && same_addr);
  end

  // Read ports: bypass the in-flight write, out-of-range reads give zero.
  always_comb begin
    rs1_ok      = in_range(vrs1_addr_i);
    rs2_ok      = in_range(vrs2_addr_i);
    rs1_byp     = wb_ok && (vwb_addr_i == vrs1_addr_i);
    rs2_byp     = wb_ok && (vwb_addr_i == vrs2_addr_i);
    vrs1_data_o = '0;
    vrs2_data_o = '0;
    vrs1_busy_o = 1'b0;
    vrs2_busy_o = 1'b0;
    if (rs1_ok) begin
      vrs1_data_o = rs1_byp ? vwb_data_i : regs[vrs1_addr_i];
      vrs1_busy_o = pending[vrs1_addr_i] && !rs1_byp;
    end
    if (rs2_ok) begin
      vrs2_data_o = rs2_byp ? vwb_data_i : regs[vrs2_addr_i];
      vrs2_busy_o = pending[vrs2_addr_i] && !rs2_byp;
    end
  end

  // Register storage, scoreboard and sticky error; issue set is applied
  // after write-back clear so a new producer wins on the same address.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VREG_NUM; i++) regs[i] <= '0;
      pending <= '0;
      err_q   <= 1'b0;
    end else begin
      if (wb_ok) begin
        regs[vwb_addr_i]    <= vwb_data_i;
        pending[vwb_addr_i] <= 1'b0;
      end
      if (iss_ok)
        pending[vid_issue_addr_i] <= 1'b1;
      err_q <= err_q | err_iss | err_wb;
    end
  end

  assign vscb_err_o = err_q;

endmodule

// File: tb/tb_v_regfile.sv
// Directed bench for v_regfile: the driver pushes hand-computed expectations
// per cycle into a queue, a negedge monitor pops and compares them.
module tb_v_regfile;

  localparam int AW = 5;
  localparam int W  = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          vwb_en_i;
  logic [AW-1:0] vwb_addr_i;
  logic [W-1:0]  vwb_data_i;
  logic          vid_issue_en_i;
  logic [AW-1:0] vid_issue_addr_i;
  logic [AW-1:0] vrs1_addr_i;
  logic [AW-1:0] vrs2_addr_i;
  logic [W-1:0]  vrs1_data_o;
  logic [W-1:0]  vrs2_data_o;
  logic          vrs1_busy_o;
  logic          vrs2_busy_o;
  logic          vscb_err_o;

  v_regfile #(.VREG_NUM(32), .VREG_AW(AW), .VLEN(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .vwb_en_i         (vwb_en_i),
    .vwb_addr_i       (vwb_addr_i),
    .vwb_data_i       (vwb_data_i),
    .vid_issue_en_i   (vid_issue_en_i),
    .vid_issue_addr_i (vid_issue_addr_i),
    .vrs1_addr_i      (vrs1_addr_i),
    .vrs2_addr_i      (vrs2_addr_i),
    .vrs1_data_o      (vrs1_data_o),
    .vrs2_data_o      (vrs2_data_o),
    .vrs1_busy_o      (vrs1_busy_o),
    .vrs2_busy_o      (vrs2_busy_o),
    .vscb_err_o       (vscb_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d1;
    logic         b1;
    logic [W-1:0] d2;
    logic         b2;
    logic         err;
    logic [4:0]   m;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  localparam logic [W-1:0] Z    = '0;
  localparam logic [W-1:0] PA5  = {(W/8){8'hA5}};
  localparam logic [W-1:0] D1234 = 256'h1234;
  localparam logic [W-1:0] D33  = 256'h33;
  localparam logic [W-1:0] D34  = 256'h34;
  localparam logic [W-1:0] D44  = 256'h44;
  localparam logic [W-1:0] D66  = 256'h66;
  localparam logic [W-1:0] D22  = 256'h22;
  localparam logic [4:0]  ALL  = 5'b11111;

  // Mask bits: [0] rs1 data, [1] rs1 busy, [2] rs2 data, [3] rs2 busy, [4] err.
  task automatic cyc(input logic r, input logic we, input logic [AW-1:0] wa,
                     input logic [W-1:0] wd, input logic ie, input logic [AW-1:0] ia,
                     input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                     input logic [W-1:0] e1, input logic eb1,
                     input logic [W-1:0] e2, input logic eb2,
                     input logic eerr, input logic [4:0] m);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; vwb_en_i = we; vwb_addr_i = wa; vwb_data_i = wd;
    vid_issue_en_i = ie; vid_issue_addr_i = ia;
    vrs1_addr_i = a1; vrs2_addr_i = a2;
    e.d1 = e1; e.b1 = eb1; e.d2 = e2; e.b2 = eb2; e.err = eerr; e.m = m;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.m[0]) begin
        n_chk++;
        if (vrs1_data_o !== e.d1) begin
          n_fail++;
          $display("FAIL rs1_data addr=%0d got=%h exp=%h", vrs1_addr_i, vrs1_data_o, e.d1);
        end
      end
      if (e.m[1]) begin
        n_chk++;
        if (vrs1_busy_o !== e.b1) begin
          n_fail++;
          $display("FAIL rs1_busy addr=%0d got=%b exp=%b", vrs1_addr_i, vrs1_busy_o, e.b1);
        end
      end
      if (e.m[2]) begin
        n_chk++;
        if (vrs2_data_o !== e.d2) begin
          n_fail++;
          $display("FAIL rs2_data addr=%0d got=%h exp=%h", vrs2_addr_i, vrs2_data_o, e.d2);
        end
      end
      if (e.m[3]) begin
        n_chk++;
        if (vrs2_busy_o !== e.b2) begin
          n_fail++;
          $display("FAIL rs2_busy addr=%0d got=%b exp=%b", vrs2_addr_i, vrs2_busy_o, e.b2);
        end
      end
      if (e.m[4]) begin
        n_chk++;
        if (vscb_err_o !== e.err) begin
          n_fail++;
          $display("FAIL scb_err t=%0t got=%b exp=%b", $time, vscb_err_o, e.err);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; vwb_en_i = 1'b0; vwb_addr_i = '0; vwb_data_i = '0;
    vid_issue_en_i = 1'b0; vid_issue_addr_i = '0;
    vrs1_addr_i = '0; vrs2_addr_i = '0;

    // Reset, then sweep all registers on both ports.
    cyc(1, 0, 0, Z, 0, 0, 0, 0, Z, 0, Z, 0, 0, 5'b00000);
    cyc(1, 0, 0, Z, 0, 0, 0, 0, Z, 0, Z, 0, 0, ALL);
    for (int i = 0; i < 32; i++)
      cyc(0, 0, 0, Z, 0, 0, AW'(i), AW'(31 - i), Z, 0, Z, 0, 0, ALL);

    // v5: issue, write with both ports bypassing, then stored read.
    cyc(0, 0, 0, Z,   1, 5, 5, 0, Z,   0, Z,   0, 0, ALL);
    cyc(0, 1, 5, PA5, 0, 0, 5, 5, PA5, 0, PA5, 0, 0, ALL);
    cyc(0, 0, 0, Z,   0, 0, 5, 0, PA5, 0, Z,   0, 0, ALL);

    // v7: busy after issue, bypassed and not busy on write-back.
    cyc(0, 0, 0, Z,     1, 7, 7, 0, Z,     0, Z, 0, 0, ALL);
    cyc(0, 0, 0, Z,     0, 0, 7, 0, Z,     1, Z, 0, 0, ALL);
    cyc(0, 1, 7, D1234, 0, 0, 7, 7, D1234, 0, D1234, 0, 0, ALL);
    cyc(0, 0, 0, Z,     0, 0, 7, 0, D1234, 0, Z, 0, 0, ALL);

    // v3: simultaneous issue and write-back while pending.
    cyc(0, 0, 0, Z,   1, 3, 3, 0, Z,   0, Z, 0, 0, ALL);
    cyc(0, 1, 3, D33, 1, 3, 3, 0, D33, 0, Z, 0, 0, ALL);
    cyc(0, 0, 0, Z,   0, 0, 3, 0, D33, 1, Z, 0, 0, ALL);
    cyc(0, 1, 3, D34, 0, 0, 3, 0, D34, 0, Z, 0, 0, ALL);
    cyc(0, 0, 0, Z,   0, 0, 3, 0, D34, 0, Z, 0, 0, ALL);

    // v9: double issue raises error one cycle after the second issue.
    cyc(0, 0, 0, Z, 1, 9, 9, 0, Z, 0, Z, 0, 0, ALL);
    cyc(0, 0, 0, Z, 1, 9, 9, 0, Z, 1, Z, 0, 0, ALL);
    cyc(0, 0, 0, Z, 0, 0, 9, 0, Z, 1, Z, 0, 1, ALL);
    // Reset cycle: stored data still visible, error still set before the edge.
    cyc(1, 0, 0, Z, 0, 0, 5, 9, PA5, 0, Z, 1, 1, ALL);
    cyc(0, 0, 0, Z, 0, 0, 5, 9, Z,   0, Z, 0, 0, ALL);

    // v4: write-back without issue still writes and flags an error.
    cyc(0, 1, 4, D44, 0, 0, 4, 0, D44, 0, Z, 0, 0, ALL);
    cyc(0, 0, 0, Z,   0, 0, 4, 0, D44, 0, Z, 0, 1, ALL);

    // v2: issue, reset (write during reset bypasses but is dropped), stale write-back.
    cyc(1, 0, 0, Z,   0, 0, 4, 0, D44, 0, Z,   0, 1, ALL);
    cyc(0, 0, 0, Z,   1, 2, 2, 4, Z,   0, Z,   0, 0, ALL);
    cyc(1, 1, 6, D66, 0, 0, 2, 6, Z,   1, D66, 0, 0, ALL);
    cyc(0, 1, 2, D22, 0, 0, 2, 6, D22, 0, Z,   0, 0, ALL);
    cyc(0, 0, 0, Z,   0, 0, 2, 6, D22, 0, Z,   0, 1, ALL);

    @(posedge clk);
    #1;
    vwb_en_i = 1'b0; vid_issue_en_i = 1'b0;
    @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain queue_left=%0d exp=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
